// File: rtl/inst_queue_pkg.sv
// Shared core definitions for the instruction queue: default widths and the
// queue entry type that couples an instruction word with its PC.

`ifndef INST_QUEUE_DEFINES
`define INST_QUEUE_DEFINES
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`endif

package inst_queue_pkg;

    // PC width held inside a stored entry; follows the core-wide address width.
    localparam int IQ_PC_WIDTH = `INST_ADDR_WIDTH;

    // One queue slot: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [31:0]            inst;
        logic [IQ_PC_WIDTH-1:0] pc;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode. Fetch pushes whole bundles of
// FETCH_WIDTH instructions; decode pops up to FETCH_WIDTH of the oldest
// entries per cycle. A flush (redirect) empties the queue at the next edge.

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int FETCH_WIDTH     = `FETCH_WIDTH,
    parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH,
    parameter int DEPTH           = 16
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    input  logic [FETCH_WIDTH-1:0][31:0]                in_inst,
    input  logic [INST_ADDR_WIDTH-1:0]                  in_pc,
    output logic                                        in_ready,
    input  logic                                        flush,
    output logic [FETCH_WIDTH-1:0]                      out_valid,
    output logic [FETCH_WIDTH-1:0][31:0]                out_inst,
    output logic [FETCH_WIDTH-1:0][INST_ADDR_WIDTH-1:0] out_pc,
    input  logic                                        out_ready,
    output logic [$clog2(DEPTH):0]                      count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Storage is deliberately not reset; occupancy alone decides validity.
    iq_entry_t          mem_q [DEPTH];

    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               enqFire;
    logic               deqFire;
    logic [CNT_W-1:0]   deqNum;

    // Handshake decisions, all based on the registered occupancy so that
    // in_ready never depends on what decode does in the same cycle.
    always_comb begin
        in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);
        enqFire  = in_valid && in_ready && !flush;
        deqFire  = out_ready && (count_q != '0) && !flush;
        deqNum   = (count_q < CNT_W'(FETCH_WIDTH)) ? count_q : CNT_W'(FETCH_WIDTH);
    end

    // Next pointer/occupancy state; flush wins over any same-cycle push or pop.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (enqFire) begin
                wrPtr_d = wrPtr_q + PTR_W'(FETCH_WIDTH);
            end
            if (deqFire) begin
                rdPtr_d = rdPtr_q + PTR_W'(deqNum);
            end
            count_d = count_q
                    + (enqFire ? CNT_W'(FETCH_WIDTH) : CNT_W'(0))
                    - (deqFire ? deqNum : CNT_W'(0));
        end
    end

    // Pointer and occupancy registers; reset empties the queue immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Write an accepted bundle; slot i gets the base PC plus 4*i.
    always_ff @(posedge clk) begin
        if (enqFire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                mem_q[PTR_W'(wrPtr_q + PTR_W'(i))].inst <= in_inst[i];
                mem_q[PTR_W'(wrPtr_q + PTR_W'(i))].pc   <=
                    IQ_PC_WIDTH'(in_pc + INST_ADDR_WIDTH'(4 * i));
            end
        end
    end

    // Present the oldest entries to decode; valid bits are contiguous from slot 0.
    always_comb begin
        out_valid = '0;
        out_inst  = '0;
        out_pc    = '0;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            out_valid[k] = CNT_W'(k) < count_q;
            out_inst[k]  = mem_q[PTR_W'(rdPtr_q + PTR_W'(k))].inst;
            out_pc[k]    = INST_ADDR_WIDTH'(mem_q[PTR_W'(rdPtr_q + PTR_W'(k))].pc);
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with two-wide bundles and an 8-entry queue.

module tb_inst_queue;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [1:0][31:0]  in_inst;
    logic [31:0]       in_pc;
    logic              in_ready;
    logic              flush;
    logic [1:0]        out_valid;
    logic [1:0][31:0]  out_inst;
    logic [1:0][31:0]  out_pc;
    logic              out_ready;
    logic [3:0]        count;

    int checks = 0;
    int errors = 0;

    inst_queue #(
        .FETCH_WIDTH    (2),
        .INST_ADDR_WIDTH(32),
        .DEPTH          (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_inst  (in_inst),
        .in_pc    (in_pc),
        .in_ready (in_ready),
        .flush    (flush),
        .out_valid(out_valid),
        .out_inst (out_inst),
        .out_pc   (out_pc),
        .out_ready(out_ready),
        .count    (count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic [31:0] inst0,
                                 input logic [31:0] inst1, input logic [31:0] pc,
                                 input logic ready, input logic fl);
        in_valid   = valid;
        in_inst[0] = inst0;
        in_inst[1] = inst1;
        in_pc      = pc;
        out_ready  = ready;
        flush      = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        // Basic flow: nothing visible before the edge, full bundle after.
        applyStimulus(1'b1, 32'h00500093, 32'h00A00113, 32'h100, 1'b0, 1'b0);
        checkOutput("no_bypass", 64'(out_valid), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("basic_valid", 64'(out_valid), 64'b11);
        checkOutput("basic_pc0", 64'(out_pc[0]), 64'h100);
        checkOutput("basic_pc1", 64'(out_pc[1]), 64'h104);
        checkOutput("basic_inst0", 64'(out_inst[0]), 64'h00500093);
        checkOutput("basic_inst1", 64'(out_inst[1]), 64'h00A00113);
        checkOutput("basic_count", 64'(count), 64'd2);

        // Drain it; the queue is empty and out_ready with no data is harmless.
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_count", 64'(count), 64'd0);
        tick();
        checkOutput("empty_ready_count", 64'(count), 64'd0);
        checkOutput("empty_ready_valid", 64'(out_valid), 64'd0);

        // Fill: four bundles with decode stalled.
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1'b1, 32'hA000_0000 + 32'(b), 32'hB000_0000 + 32'(b),
                          32'h200 + 32'(8 * b), 1'b0, 1'b0);
            tick();
        end
        checkOutput("full_count", 64'(count), 64'd8);
        checkOutput("full_ready", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, 32'hDEAD0000, 32'hDEAD0001, 32'h900, 1'b0, 1'b0);
        tick();
        checkOutput("full_reject_count", 64'(count), 64'd8);
        checkOutput("full_head_pc", 64'(out_pc[0]), 64'h200);
        checkOutput("full_head_inst1", 64'(out_inst[1]), 64'hB0000000);

        // Pop one bundle: count 6, next bundle at the head.
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("pop_count", 64'(count), 64'd6);
        checkOutput("pop_head_pc", 64'(out_pc[0]), 64'h208);

        // Simultaneous push and pop at count 6.
        applyStimulus(1'b1, 32'hC0, 32'hC1, 32'h300, 1'b1, 1'b0);
        checkOutput("simul_ready", 64'(in_ready), 64'd1);
        tick();
        checkOutput("simul_count", 64'(count), 64'd6);
        checkOutput("simul_head_pc", 64'(out_pc[0]), 64'h210);

        // Pop to count 4, then flush with push and pop also requested.
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("pre_flush_count", 64'(count), 64'd4);
        applyStimulus(1'b1, 32'hF0, 32'hF1, 32'h700, 1'b1, 1'b1);
        tick();
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_ready", 64'(in_ready), 64'd1);

        // Preload three bundles, then stream 20 cycles of push+pop through the wrap.
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b1, 32'h5000 + 32'(b), 32'h6000 + 32'(b),
                          32'h1000 + 32'(8 * b), 1'b0, 1'b0);
            tick();
        end
        for (int j = 0; j < 20; j++) begin
            checkOutput($sformatf("wrap_count_%0d", j), 64'(count), 64'd6);
            checkOutput($sformatf("wrap_pc0_%0d", j), 64'(out_pc[0]), 64'(32'h1000 + 32'(8 * j)));
            checkOutput($sformatf("wrap_pc1_%0d", j), 64'(out_pc[1]), 64'(32'h1004 + 32'(8 * j)));
            checkOutput($sformatf("wrap_inst0_%0d", j), 64'(out_inst[0]), 64'(32'h5000 + 32'(j)));
            applyStimulus(1'b1, 32'h5000 + 32'(j + 3), 32'h6000 + 32'(j + 3),
                          32'h1000 + 32'(8 * (j + 3)), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("wrap_end_count", 64'(count), 64'd6);
        checkOutput("wrap_end_pc", 64'(out_pc[0]), 64'h10A0);

        // Asynchronous reset pulse between edges while holding six entries.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_valid", 64'(out_valid), 64'd0);
        checkOutput("async_count", 64'(count), 64'd0);
        checkOutput("async_ready", 64'(in_ready), 64'd1);
        #1;
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 32'h77, 32'h88, 32'h500, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("post_rst_count", 64'(count), 64'd2);
        checkOutput("post_rst_pc0", 64'(out_pc[0]), 64'h500);
        checkOutput("post_rst_inst1", 64'(out_inst[1]), 64'h88);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
